// File: rtl/ahbl_master_arb_if.sv
// ---------------------------------------------------------------------------
// ahbl_master_arb_if
// Bundles the two-requester side and the AHB-Lite master side of
// ahbl_master_arb.
//   master modport : the arbiter's view (drives AHB address/data, completions)
//   slave  modport : the environment's view (requesters plus the AHB slave)
// Requester n owns bit n of req_valid/req_write/req_done/req_err,
// req_size[3n+2:3n], req_addr[32n+31:32n] and req_wdata[32n+31:32n].
// ---------------------------------------------------------------------------
interface ahbl_master_arb_if;
    // requester side
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [5:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] rdata;
    logic        grant_id;
    logic        timeout_err;
    // AHB-Lite master side
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        input  hrdata, hready, hresp,
        output req_done, req_err, rdata, grant_id, timeout_err,
        output haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        output hrdata, hready, hresp,
        input  req_done, req_err, rdata, grant_id, timeout_err,
        input  haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata
    );
endinterface

// File: rtl/ahbl_master_arb.sv
// ---------------------------------------------------------------------------
// ahbl_master_arb
// Two-requester round-robin arbiter driving a single AHB-Lite master port.
// One non-overlapped single transfer at a time: IDLE -> ADDR -> DATA -> RESP.
// Ports:
//   hclk_i    : clock, all state on the rising edge
//   hreset_i  : synchronous active-high reset
//   ahb_io    : ahbl_master_arb_if.master (requesters + AHB-Lite master)
// Parameter:
//   TIMEOUT   : DATA-phase wait-state count that sets the sticky timeout flag
//               (1..65535)
// ---------------------------------------------------------------------------
module ahbl_master_arb #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              hclk_i,
    input  logic              hreset_i,
    ahbl_master_arb_if.master ahb_io
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    state_e      state_q, state_d;
    logic        last_q;      // requester granted most recently
    logic        grant_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        tout_q;
    logic [15:0] wait_q, wait_d;
    logic        win_id;
    logic        grant_en;
    logic        wait_hit;

    // Round-robin: on contention the requester not granted last wins.
    always_comb begin
        if (&ahb_io.req_valid) win_id = ~last_q;
        else                   win_id = ahb_io.req_valid[1];
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            S_IDLE: if (|ahb_io.req_valid) begin
                state_d  = S_ADDR;
                grant_en = 1'b1;
            end
            S_ADDR:  if (ahb_io.hready) state_d = S_DATA;
            S_DATA:  if (ahb_io.hready) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter clears when the address phase is accepted (entry to DATA)
    // and saturates rather than wrapping during a very long stall.
    always_comb begin
        wait_d = wait_q;
        if (state_q == S_ADDR && ahb_io.hready)
            wait_d = '0;
        else if (state_q == S_DATA && !ahb_io.hready && wait_q != 16'hFFFF)
            wait_d = wait_q + 16'd1;
    end

    // Fires on the wait cycle that brings the count up to TIMEOUT.
    assign wait_hit = (state_q == S_DATA) && !ahb_io.hready &&
                      (({1'b0, wait_q} + 17'd1) >= 17'(TIMEOUT));

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 3'b010;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (grant_en) begin
                grant_q <= win_id;
                last_q  <= win_id;
                write_q <= ahb_io.req_write[win_id];
                size_q  <= win_id ? ahb_io.req_size[5:3]   : ahb_io.req_size[2:0];
                addr_q  <= win_id ? ahb_io.req_addr[63:32] : ahb_io.req_addr[31:0];
                wdata_q <= win_id ? ahb_io.req_wdata[63:32] : ahb_io.req_wdata[31:0];
            end
            if (state_q == S_DATA && ahb_io.hready) begin
                err_q <= ahb_io.hresp;
                if (!write_q) rdata_q <= ahb_io.hrdata;
            end
            if (wait_hit) tout_q <= 1'b1;
        end
    end

    // Address-phase fields are register outputs, so they naturally hold
    // their last values outside ADDR.
    assign ahb_io.htrans      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign ahb_io.haddr       = addr_q;
    assign ahb_io.hwrite      = write_q;
    assign ahb_io.hsize       = size_q;
    assign ahb_io.hwdata      = wdata_q;
    assign ahb_io.hburst      = 3'b000;
    assign ahb_io.hprot       = 4'b0011;
    assign ahb_io.hmastlock   = 1'b0;
    assign ahb_io.req_done    = (state_q == S_RESP) ? (2'b01 << grant_q) : 2'b00;
    assign ahb_io.req_err     = (state_q == S_RESP && err_q) ? (2'b01 << grant_q) : 2'b00;
    assign ahb_io.rdata       = rdata_q;
    assign ahb_io.grant_id    = grant_q;
    assign ahb_io.timeout_err = tout_q;
endmodule

// File: tb/tb_ahbl_master_arb.sv
module tb_ahbl_master_arb;
    localparam int TO = 4;

    logic hclk;
    logic hreset;
    ahbl_master_arb_if bus();

    ahbl_master_arb #(.TIMEOUT(TO)) dut (
        .hclk_i  (hclk),
        .hreset_i(hreset),
        .ahb_io  (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One transfer in flight at a time; m_pos counts how far it has got:
    // 0 = address offered, 1 = data phase, 2 = completion reported.
    bit          m_init = 0;
    bit          m_busy;
    int          m_pos;
    bit          m_who, m_last, m_write, m_err, m_tout;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_waits;

    initial forever begin
        @(posedge hclk);
        cyc++;
        if (hreset) begin
            m_init = 1; m_busy = 0; m_pos = 0; m_who = 0; m_last = 1;
            m_write = 0; m_err = 0; m_tout = 0; m_size = 3'd2;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_waits = 0;
        end else if (!m_busy) begin
            if (bus.req_valid != 2'b00) begin
                if (bus.req_valid == 2'b11) m_who = !m_last;
                else                        m_who = (bus.req_valid == 2'b10);
                m_last  = m_who;
                m_write = bus.req_write[m_who];
                m_size  = bus.req_size[3*m_who +: 3];
                m_addr  = bus.req_addr[32*m_who +: 32];
                m_wdata = bus.req_wdata[32*m_who +: 32];
                m_busy  = 1;
                m_pos   = 0;
            end
        end else begin
            if (m_pos == 0) begin
                if (bus.hready) begin m_pos = 1; m_waits = 0; end
            end else if (m_pos == 1) begin
                if (bus.hready) begin
                    m_pos = 2;
                    m_err = bus.hresp;
                    if (!m_write) m_rdata = bus.hrdata;
                end else begin
                    m_waits++;
                    if (m_waits == TO) m_tout = 1;
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        logic [1:0] e_trans, e_done;
        @(negedge hclk);
        if (m_init) begin
            e_trans = (m_busy && m_pos == 0) ? 2'b10 : 2'b00;
            e_done  = (m_busy && m_pos == 2) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
            chk("htrans",    32'(bus.htrans),      32'(e_trans));
            chk("haddr",     bus.haddr,            m_addr);
            chk("hwrite",    32'(bus.hwrite),      32'(m_write));
            chk("hsize",     32'(bus.hsize),       32'(m_size));
            chk("hwdata",    bus.hwdata,           m_wdata);
            chk("req_done",  32'(bus.req_done),    32'(e_done));
            chk("rdata",     bus.rdata,            m_rdata);
            chk("grant_id",  32'(bus.grant_id),    32'(m_who));
            chk("tout",      32'(bus.timeout_err), 32'(m_tout));
            chk("hburst",    32'(bus.hburst),      32'd0);
            chk("hprot",     32'(bus.hprot),       32'd3);
            chk("hmastlock", 32'(bus.hmastlock),   32'd0);
            if (e_done != 2'b00)
                chk("req_err", 32'(bus.req_err), m_err ? 32'(e_done) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
    endtask

    // One complete transfer from a single requester; fields are scrambled
    // right after the grant so any late sampling shows up as a mismatch.
    task automatic xfer(input int id, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input bit er,
                        output logic [1:0] dn, output logic [1:0] ee,
                        output logic [31:0] rdo);
        bus.req_valid             = 2'b00;
        bus.req_valid[id]         = 1'b1;
        bus.req_write[id]         = wr;
        bus.req_size[3*id +: 3]   = sz;
        bus.req_addr[32*id +: 32] = a;
        bus.req_wdata[32*id +: 32]= d;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        tick();                               // ADDR
        bus.req_valid = 2'b00;
        bus.req_addr  = ~bus.req_addr;
        bus.req_wdata = ~bus.req_wdata;
        bus.req_write = ~bus.req_write;
        bus.req_size  = ~bus.req_size;
        tick();                               // DATA
        for (int i = 0; i < waits; i++) begin
            bus.hready = 1'b0;
            bus.hresp  = er && (i == waits - 1);
            tick();
        end
        bus.hready = 1'b1;
        bus.hresp  = er;
        bus.hrdata = rd;
        tick();                               // RESP
        dn  = bus.req_done;
        ee  = bus.req_err;
        rdo = bus.rdata;
        bus.hresp  = 1'b0;
        bus.hrdata = 32'hBAD0_BAD0;
        tick();                               // IDLE
    endtask

    initial begin
        logic [1:0]  dn, ee;
        logic [31:0] rdo;
        logic [1:0]  order[4];
        int          tdone[4];
        int          seen;

        hreset = 1'b1;
        bus.req_valid = '0; bus.req_write = '0; bus.req_size = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus.hrdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
        do_reset();

        // reset state
        chk("rst_htrans", 32'(bus.htrans), 32'd0);
        chk("rst_haddr",  bus.haddr, 32'd0);
        chk("rst_hsize",  32'(bus.hsize), 32'd2);
        chk("rst_done",   32'(bus.req_done), 32'd0);
        chk("rst_rdata",  bus.rdata, 32'd0);
        chk("rst_tout",   32'(bus.timeout_err), 32'd0);

        // requester 0 write, zero waits, literal timing
        bus.req_valid = 2'b01; bus.req_write = 2'b01; bus.req_size = 6'o02;
        bus.req_addr = 64'h0000_0000_0000_0040;
        bus.req_wdata = 64'h0000_0000_DEAD_BEEF;
        tick();
        chk("w0_htrans", 32'(bus.htrans), 32'd2);
        chk("w0_haddr",  bus.haddr, 32'h40);
        chk("w0_hwrite", 32'(bus.hwrite), 32'd1);
        bus.req_valid = 2'b00; bus.req_addr = 64'h999; bus.req_wdata = 64'h1;
        tick();
        chk("w0_data_htrans", 32'(bus.htrans), 32'd0);
        chk("w0_hwdata", bus.hwdata, 32'hDEADBEEF);
        chk("w0_haddr_hold", bus.haddr, 32'h40);
        tick();
        chk("w0_done", 32'(bus.req_done), 32'd1);
        chk("w0_err",  32'(bus.req_err), 32'd0);
        tick();
        chk("w0_done_off", 32'(bus.req_done), 32'd0);

        // requester 1 read with 3 wait states
        xfer(1, 1'b0, 3'd2, 32'h80, 32'h0, 3, 32'h1234_5678, 1'b0, dn, ee, rdo);
        chk("r1_done",  32'(dn), 32'd2);
        chk("r1_rdata", rdo, 32'h1234_5678);
        chk("r1_grant", 32'(bus.grant_id), 32'd1);

        // write leaves RDATA untouched
        xfer(0, 1'b1, 3'd1, 32'h44, 32'hCAFE_F00D, 0, 32'h5555_5555, 1'b0, dn, ee, rdo);
        chk("w_rdata_hold", rdo, 32'h1234_5678);
        chk("w_done", 32'(dn), 32'd1);

        // contention from reset: alternating grants, 4 cycles apart
        do_reset();
        bus.req_valid = 2'b11; bus.req_write = 2'b01; bus.req_size = 6'o22;
        bus.req_addr = {32'h200, 32'h100};
        bus.req_wdata = {32'h0, 32'hAAAA_0001};
        bus.hready = 1'b1; bus.hrdata = 32'hA5A5_0000;
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            tick();
            if (bus.req_done != 2'b00) begin
                order[seen] = bus.req_done;
                tdone[seen] = cyc;
                seen++;
                if (seen == 4) bus.req_valid = 2'b00;
            end
        end
        chk("rr_count", 32'(seen), 32'd4);
        chk("rr_g0", 32'(order[0]), 32'd1);
        chk("rr_g1", 32'(order[1]), 32'd2);
        chk("rr_g2", 32'(order[2]), 32'd1);
        chk("rr_g3", 32'(order[3]), 32'd2);
        for (int i = 1; i < 4; i++)
            chk("rr_spacing", 32'(tdone[i] - tdone[i-1]), 32'd4);
        tick();

        // two-cycle ERROR response, then a clean transfer
        xfer(0, 1'b1, 3'd2, 32'h300, 32'h0BAD_0BAD, 1, 32'h0, 1'b1, dn, ee, rdo);
        chk("err_done", 32'(dn), 32'd1);
        chk("err_flag", 32'(ee), 32'd1);
        xfer(0, 1'b1, 3'd2, 32'h304, 32'h600D_600D, 0, 32'h0, 1'b0, dn, ee, rdo);
        chk("noerr_done", 32'(dn), 32'd1);
        chk("noerr_flag", 32'(ee), 32'd0);

        // wait-state timeout: sticky, transfer still completes
        chk("to_before", 32'(bus.timeout_err), 32'd0);
        xfer(1, 1'b0, 3'd2, 32'h400, 32'h0, 10, 32'h7777_8888, 1'b0, dn, ee, rdo);
        chk("to_done", 32'(dn), 32'd2);
        chk("to_rdata", rdo, 32'h7777_8888);
        chk("to_flag", 32'(bus.timeout_err), 32'd1);
        xfer(0, 1'b1, 3'd2, 32'h404, 32'h1, 0, 32'h0, 1'b0, dn, ee, rdo);
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);

        // reset in the data phase abandons the transfer
        bus.req_valid = 2'b01; bus.req_write = 2'b01; bus.req_addr = 64'h500;
        bus.req_wdata = 64'h2; bus.hready = 1'b1;
        tick();
        chk("rd_addr_ph", 32'(bus.htrans), 32'd2);
        bus.req_valid = 2'b00;
        tick();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        chk("rd_htrans", 32'(bus.htrans), 32'd0);
        chk("rd_done",   32'(bus.req_done), 32'd0);
        chk("rd_haddr",  bus.haddr, 32'd0);
        chk("rd_tout",   32'(bus.timeout_err), 32'd0);
        tick();
        chk("rd_done2",  32'(bus.req_done), 32'd0);
        xfer(0, 1'b0, 3'd2, 32'h600, 32'h0, 0, 32'h0F0F_0F0F, 1'b0, dn, ee, rdo);
        chk("rd_new_done",  32'(dn), 32'd1);
        chk("rd_new_rdata", rdo, 32'h0F0F_0F0F);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
